// File: rtl/ysyx_040066_clint_n_pkg.sv
// Shared CLINT address map, register-select encoding and byte-merge helper.
// Used by the decoder and the top; no logic of its own.
package ysyx_040066_clint_n_pkg;

    localparam logic [15:0] MSIP_OFF  = 16'h0000;
    localparam logic [15:0] CMP_OFF   = 16'h4000;
    localparam logic [15:0] MTIME_OFF = 16'hBFF8;
    localparam logic [63:0] WINDOW    = 64'h0000_0000_0001_0000;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_MSIP,
        SEL_CMP,
        SEL_MTIME
    } sel_t;

    function automatic logic [63:0] merge_bytes(input logic [63:0] old_val,
                                                input logic [63:0] new_val,
                                                input logic [7:0]  mask);
        logic [63:0] res;
        res = old_val;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ysyx_040066_clint_decode.sv
// Combinational window/register decoder: hit, register select, hart index, fault.
// Zero latency; no flow control of its own.
module ysyx_040066_clint_decode
    import ysyx_040066_clint_n_pkg::*;
#(
    parameter int          NHART = 1,
    parameter logic [63:0] BASE  = 64'h0000_0000_0200_0000
) (
    input  logic [63:0] addr,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic [7:0]  wr_mask,
    output logic        hit,
    output sel_t        sel,
    output logic [3:0]  hart,
    output logic        err
);

    logic [63:0] offset;
    logic [15:0] off;
    logic [13:0] idx;
    logic        bad;

    assign offset = addr - BASE;
    assign off    = offset[15:0];
    assign hit    = (addr >= BASE) && (offset < WINDOW) && (MemRd || MemWr);

    always_comb begin
        sel = SEL_NONE;
        idx = '0;
        bad = 1'b0;
        if (off < CMP_OFF) begin
            sel = SEL_MSIP;
            idx = 14'((off - MSIP_OFF) >> 2);
            bad = (off[1:0] != 2'b00);
        end else if (off < MTIME_OFF) begin
            sel = SEL_CMP;
            idx = 14'((off - CMP_OFF) >> 3);
            bad = (off[2:0] != 3'b000);
        end else if (off <= MTIME_OFF + 16'd7) begin
            sel = SEL_MTIME;
            bad = (off[2:0] != 3'b000);
        end else begin
            bad = 1'b1;
        end
        // Slots past the last implemented hart decode like holes in the map.
        if ((sel == SEL_MSIP || sel == SEL_CMP) && idx >= 14'(NHART)) begin
            bad = 1'b1;
        end
        hart = idx[3:0];
        err  = bad || (MemRd && MemWr) || (MemWr && (wr_mask == 8'h00));
    end

endmodule

// File: rtl/ysyx_040066_clint_n.sv
// Multi-hart CLINT on the M-stage data path: shared mtime, per-hart mtimecmp/msip.
// Fixed 1-cycle response, always ready, no back-pressure; misses forwarded to the bus.
module ysyx_040066_clint_n
    import ysyx_040066_clint_n_pkg::*;
#(
    parameter int          NHART    = 1,
    parameter logic [63:0] BASE     = 64'h0000_0000_0200_0000,
    parameter int          TICK_DIV = 1,
    parameter logic [63:0] CMP_RST  = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MemRd,
    input  logic             MemWr,
    input  logic [63:0]      addr,
    input  logic [63:0]      data,
    input  logic [7:0]       wr_mask,
    output logic             hit,
    output logic             MemRd_real,
    output logic             MemWr_real,
    output logic             resp_valid,
    output logic [63:0]      rd_data,
    output logic             error,
    output logic [NHART-1:0] msip,
    output logic [NHART-1:0] mtip
);

    sel_t        sel;
    logic [3:0]  hart;
    logic        dec_err;
    logic        acc;
    logic        do_rd;
    logic        do_wr;
    logic        lane;
    logic [31:0] pre;
    logic        tick;
    logic [63:0] mtime;
    logic [63:0] mtime_next;
    logic [63:0] rd_next;
    logic [63:0] cmp      [NHART];
    logic [63:0] cmp_next [NHART];
    logic [NHART-1:0] msip_next;
    logic [NHART-1:0] mtip_next;

    ysyx_040066_clint_decode #(
        .NHART (NHART),
        .BASE  (BASE)
    ) u_decode (
        .addr    (addr),
        .MemRd   (MemRd),
        .MemWr   (MemWr),
        .wr_mask (wr_mask),
        .hit     (hit),
        .sel     (sel),
        .hart    (hart),
        .err     (dec_err)
    );

    assign acc        = hit & ~dec_err;
    assign do_rd      = acc & MemRd;
    assign do_wr      = acc & MemWr;
    assign lane       = addr[2];
    assign MemRd_real = MemRd & ~hit;
    assign MemWr_real = MemWr & ~hit;
    assign tick       = (pre == 32'(TICK_DIV - 1));

    always_comb begin
        rd_next   = '0;
        msip_next = msip;
        mtip_next = '0;
        // Tick first, then overlay written bytes: the store wins where it lands.
        mtime_next = mtime + 64'(tick);
        if (do_wr && sel == SEL_MTIME) begin
            mtime_next = merge_bytes(mtime_next, data, wr_mask);
        end
        if (do_rd && sel == SEL_MTIME) begin
            rd_next = mtime;
        end
        for (int h = 0; h < NHART; h++) begin
            cmp_next[h] = cmp[h];
            if (hart == 4'(h)) begin
                if (do_wr && sel == SEL_CMP) begin
                    cmp_next[h] = merge_bytes(cmp[h], data, wr_mask);
                end
                if (do_wr && sel == SEL_MSIP && (lane ? wr_mask[4] : wr_mask[0])) begin
                    msip_next[h] = lane ? data[32] : data[0];
                end
                if (do_rd && sel == SEL_CMP) begin
                    rd_next = cmp[h];
                end
                if (do_rd && sel == SEL_MSIP) begin
                    rd_next = lane ? {31'b0, msip[h], 32'b0} : {32'b0, 31'b0, msip[h]};
                end
            end
            mtip_next[h] = (mtime_next >= cmp_next[h]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pre        <= '0;
            mtime      <= '0;
            msip       <= '0;
            mtip       <= '0;
            resp_valid <= 1'b0;
            rd_data    <= '0;
            error      <= 1'b0;
            for (int h = 0; h < NHART; h++) begin
                cmp[h] <= CMP_RST;
            end
        end else begin
            pre        <= tick ? '0 : pre + 32'd1;
            mtime      <= mtime_next;
            msip       <= msip_next;
            mtip       <= mtip_next;
            resp_valid <= hit;
            rd_data    <= rd_next;
            error      <= hit & dec_err;
            for (int h = 0; h < NHART; h++) begin
                cmp[h] <= cmp_next[h];
            end
        end
    end

endmodule

// File: tb/tb_ysyx_040066_clint_n.sv
// Two CLINTs (TICK_DIV=4 and 1) driven in lockstep and checked each cycle against a reference model.
module tb_ysyx_040066_clint_n;

    localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;
    localparam int          NH   = 2;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        mem_rd;
    logic        mem_wr;
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  wr_mask;

    logic [1:0]         hit_v;
    logic [1:0]         rdr_v;
    logic [1:0]         wrr_v;
    logic [1:0]         rv_v;
    logic [1:0]         err_v;
    logic [1:0][63:0]   rd_v;
    logic [1:0][NH-1:0] msip_v;
    logic [1:0][NH-1:0] mtip_v;

    ysyx_040066_clint_n #(.NHART(NH), .BASE(BASE), .TICK_DIV(4), .CMP_RST(ONES)) dut_div4 (
        .clk(clk), .rst(rst), .MemRd(mem_rd), .MemWr(mem_wr), .addr(addr), .data(data),
        .wr_mask(wr_mask), .hit(hit_v[0]), .MemRd_real(rdr_v[0]), .MemWr_real(wrr_v[0]),
        .resp_valid(rv_v[0]), .rd_data(rd_v[0]), .error(err_v[0]), .msip(msip_v[0]), .mtip(mtip_v[0])
    );

    ysyx_040066_clint_n #(.NHART(NH), .BASE(BASE), .TICK_DIV(1), .CMP_RST(ONES)) dut_div1 (
        .clk(clk), .rst(rst), .MemRd(mem_rd), .MemWr(mem_wr), .addr(addr), .data(data),
        .wr_mask(wr_mask), .hit(hit_v[1]), .MemRd_real(rdr_v[1]), .MemWr_real(wrr_v[1]),
        .resp_valid(rv_v[1]), .rd_data(rd_v[1]), .error(err_v[1]), .msip(msip_v[1]), .mtip(mtip_v[1])
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model state, one slot per instance (0: TICK_DIV=4, 1: TICK_DIV=1).
    int unsigned tdiv [2] = '{4, 1};
    int unsigned m_cyc   [2];
    logic [63:0] m_mtime [2];
    logic [63:0] m_cmp   [2][NH];
    logic [NH-1:0] m_msip [2];
    logic [NH-1:0] m_mtip [2];
    logic        e_rv  [2];
    logic        e_err [2];
    logic [63:0] e_rd  [2];
    logic        last_hit;

    function automatic void classify(input logic [63:0] a, input logic rd, input logic wr,
                                     input logic [7:0] m, output logic in_win, output logic bad,
                                     output int kind, output int h);
        logic [63:0] off;
        off    = a - BASE;
        in_win = (a >= BASE) && (off < 64'h10000) && (rd || wr);
        kind   = 0;
        h      = 0;
        bad    = 1'b0;
        if (off % 4 == 0 && off / 4 < NH) begin
            kind = 1;
            h    = int'(off / 4);
        end else if (off >= 64'h4000 && off < 64'h4000 + 8 * NH && off % 8 == 0) begin
            kind = 2;
            h    = int'((off - 64'h4000) / 8);
        end else if (off == 64'hBFF8) begin
            kind = 3;
        end else begin
            bad = 1'b1;
        end
        if (rd && wr) bad = 1'b1;
        if (wr && m == 8'h00) bad = 1'b1;
    endfunction

    task automatic model_step(input int k, input logic r, input logic rd, input logic wr,
                              input logic [63:0] a, input logic [63:0] d, input logic [7:0] m);
        logic        inw;
        logic        bad;
        int          kind;
        int          h;
        logic [63:0] nt;
        if (!r) begin
            m_cyc[k]   = 0;
            m_mtime[k] = 64'd0;
            m_msip[k]  = '0;
            m_mtip[k]  = '0;
            for (int i = 0; i < NH; i++) m_cmp[k][i] = ONES;
            e_rv[k]  = 1'b0;
            e_err[k] = 1'b0;
            e_rd[k]  = 64'd0;
            return;
        end
        classify(a, rd, wr, m, inw, bad, kind, h);
        nt = m_mtime[k] + ((m_cyc[k] % tdiv[k] == tdiv[k] - 1) ? 64'd1 : 64'd0);
        m_cyc[k]++;
        e_rv[k]  = inw;
        e_err[k] = inw && bad;
        e_rd[k]  = 64'd0;
        if (inw && !bad) begin
            if (rd) begin
                if (kind == 1) e_rd[k] = 64'(m_msip[k][h]) << (a[2] ? 32 : 0);
                if (kind == 2) e_rd[k] = m_cmp[k][h];
                if (kind == 3) e_rd[k] = m_mtime[k];
            end
            if (wr) begin
                for (int i = 0; i < 8; i++) begin
                    if (m[i] && kind == 3) nt[8*i +: 8] = d[8*i +: 8];
                    if (m[i] && kind == 2) m_cmp[k][h][8*i +: 8] = d[8*i +: 8];
                end
                if (kind == 1 && (a[2] ? m[4] : m[0])) m_msip[k][h] = a[2] ? d[32] : d[0];
            end
        end
        m_mtime[k] = nt;
        for (int i = 0; i < NH; i++) m_mtip[k][i] = (m_mtime[k] >= m_cmp[k][i]);
    endtask

    // One clock: drive at negedge, check combinational outputs, then registered ones after posedge.
    task automatic step(input logic r, input logic rd, input logic wr,
                        input logic [63:0] a, input logic [63:0] d, input logic [7:0] m);
        logic inw;
        logic bad;
        int   kind;
        int   h;
        rst = r; mem_rd = rd; mem_wr = wr; addr = a; data = d; wr_mask = m;
        #1;
        classify(a, rd, wr, m, inw, bad, kind, h);
        last_hit = hit_v[1];
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("hit[%0d] @%h", k, a), 64'(hit_v[k]), 64'(inw));
            chk($sformatf("MemRd_real[%0d]", k), 64'(rdr_v[k]), 64'(rd && !inw));
            chk($sformatf("MemWr_real[%0d]", k), 64'(wrr_v[k]), 64'(wr && !inw));
            model_step(k, r, rd, wr, a, d, m);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("resp_valid[%0d]", k), 64'(rv_v[k]), 64'(e_rv[k]));
            chk($sformatf("error[%0d]", k), 64'(err_v[k]), 64'(e_err[k]));
            chk($sformatf("rd_data[%0d]", k), rd_v[k], e_rd[k]);
            chk($sformatf("msip[%0d]", k), 64'(msip_v[k]), 64'(m_msip[k]));
            chk($sformatf("mtip[%0d]", k), 64'(mtip_v[k]), 64'(m_mtip[k]));
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 64'd0, 64'd0, 8'h00);
    endtask

    task automatic rd_req(input logic [63:0] off);
        step(1'b1, 1'b1, 1'b0, BASE + off, 64'd0, 8'h00);
    endtask

    task automatic wr_req(input logic [63:0] off, input logic [63:0] d, input logic [7:0] m);
        step(1'b1, 1'b0, 1'b1, BASE + off, d, m);
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [63:0] a;
        logic [7:0]  m;
        logic        exp_hit;
        logic        exp_err;
        string       name;
    } vec_t;

    function automatic vec_t mk(input logic rd, input logic wr, input logic [63:0] a,
                                input logic [7:0] m, input logic eh, input logic ee, input string n);
        vec_t v;
        v.rd = rd; v.wr = wr; v.a = a; v.m = m; v.exp_hit = eh; v.exp_err = ee; v.name = n;
        return v;
    endfunction

    initial begin
        vec_t        tbl [13];
        logic [63:0] offs [11];
        logic [63:0] a;
        logic [63:0] d;
        logic [7:0]  m;
        logic        rd;
        logic        wr;
        logic        r;

        tbl[0]  = mk(1, 0, BASE + 64'h4004,  8'h00, 1, 1, "cmp misaligned");
        tbl[1]  = mk(1, 0, BASE + 64'h5000,  8'h00, 1, 1, "cmp hart 0x200");
        tbl[2]  = mk(1, 0, BASE + 64'h4010,  8'h00, 1, 1, "cmp hart NHART");
        tbl[3]  = mk(1, 1, BASE + 64'hBFF8,  8'hFF, 1, 1, "rd and wr");
        tbl[4]  = mk(0, 1, BASE + 64'hBFF8,  8'h00, 1, 1, "wr mask zero");
        tbl[5]  = mk(1, 0, BASE + 64'h0008,  8'h00, 1, 1, "msip hart NHART");
        tbl[6]  = mk(1, 0, BASE + 64'h0002,  8'h00, 1, 1, "msip misaligned");
        tbl[7]  = mk(1, 0, BASE + 64'hBFFC,  8'h00, 1, 1, "mtime misaligned");
        tbl[8]  = mk(1, 0, BASE + 64'hFFF8,  8'h00, 1, 1, "unmapped top");
        tbl[9]  = mk(1, 0, 64'h8000_0000,    8'h00, 0, 0, "dram load");
        tbl[10] = mk(1, 0, BASE - 64'd8,     8'h00, 0, 0, "below window");
        tbl[11] = mk(0, 1, BASE + 64'h10000, 8'hFF, 0, 0, "above window");
        tbl[12] = mk(1, 0, BASE + 64'h4008,  8'h00, 1, 0, "cmp1 load ok");

        offs = '{64'h0, 64'h4, 64'h8, 64'h2, 64'h4000, 64'h4008, 64'h4010,
                 64'h4004, 64'hBFF8, 64'hBFFC, 64'hC000};

        rst = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; addr = '0; data = '0; wr_mask = '0;
        @(negedge clk);

        // Reset state
        repeat (3) step(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 8'h00);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset resp_valid[%0d]", k), 64'(rv_v[k]), 64'd0);
            chk($sformatf("reset rd_data[%0d]", k), rd_v[k], 64'd0);
            chk($sformatf("reset msip[%0d]", k), 64'(msip_v[k]), 64'd0);
            chk($sformatf("reset mtip[%0d]", k), 64'(mtip_v[k]), 64'd0);
        end

        // Prescaled mtime after 40 idle cycles
        repeat (40) idle();
        rd_req(64'hBFF8);
        chk("mtime div4 after 40", rd_v[0], 64'd10);
        chk("mtime div1 after 40", rd_v[1], 64'd40);
        chk("resp_valid one cycle after read", 64'(rv_v[0]), 64'd1);
        rd_req(64'h4000);
        chk("mtimecmp0 reset div4", rd_v[0], ONES);
        chk("mtimecmp0 reset div1", rd_v[1], ONES);
        idle();
        chk("resp_valid drops", 64'(rv_v[0]), 64'd0);

        // Timer interrupt on hart 1
        wr_req(64'hBFF8, 64'd0, 8'hFF);
        wr_req(64'h4008, 64'd20, 8'hFF);
        repeat (18) idle();
        chk("mtip1 before 20", 64'(mtip_v[1][1]), 64'd0);
        idle();
        chk("mtip1 at 20", 64'(mtip_v[1][1]), 64'd1);
        chk("mtip0 stays low", 64'(mtip_v[1][0]), 64'd0);
        wr_req(64'h4008, ONES, 8'hFF);
        chk("mtip1 cleared", 64'(mtip_v[1][1]), 64'd0);

        // mtime wrap and tick/write byte merge
        wr_req(64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
        rd_req(64'hBFF8);
        chk("mtime after write", rd_v[1], 64'hFFFF_FFFF_FFFF_FFFE);
        rd_req(64'hBFF8);
        chk("mtime max", rd_v[1], ONES);
        rd_req(64'hBFF8);
        chk("mtime wrapped", rd_v[1], 64'd0);
        wr_req(64'hBFF8, 64'h0000_0000_FFFF_FFFF, 8'hFF);
        wr_req(64'hBFF8, 64'h5555_5555_1234_5678, 8'h0F);
        rd_req(64'hBFF8);
        chk("mtime low-mask merge", rd_v[1], 64'h0000_0001_1234_5678);

        // Software interrupt lanes
        wr_req(64'h4, 64'h0000_0001_0000_0000, 8'hF0);
        chk("msip hart1 set", 64'(msip_v[1]), 64'h2);
        rd_req(64'h0);
        chk("msip0 read", rd_v[1], 64'd0);
        rd_req(64'h4);
        chk("msip1 read", rd_v[1], 64'h0000_0001_0000_0000);

        // Decode / error table
        for (int i = 0; i < 13; i++) begin
            step(1'b1, tbl[i].rd, tbl[i].wr, tbl[i].a, 64'hDEAD_BEEF_0000_0001, tbl[i].m);
            chk({tbl[i].name, " hit"}, 64'(last_hit), 64'(tbl[i].exp_hit));
            chk({tbl[i].name, " resp_valid"}, 64'(rv_v[1]), 64'(tbl[i].exp_hit));
            chk({tbl[i].name, " error"}, 64'(err_v[1]), 64'(tbl[i].exp_err));
        end
        chk("cmp1 untouched by faults", rd_v[1], ONES);
        chk("msip untouched by faults", 64'(msip_v[1]), 64'h2);

        // Reset right after a hit drops the response
        rd_req(64'hBFF8);
        step(1'b0, 1'b1, 1'b0, BASE + 64'hBFF8, 64'd0, 8'h00);
        chk("reset drops resp_valid", 64'(rv_v[1]), 64'd0);
        chk("reset clears msip", 64'(msip_v[1]), 64'd0);
        chk("reset clears rd_data", rd_v[1], 64'd0);
        rd_req(64'hBFF8);
        chk("mtime from reset", rd_v[1], 64'd0);
        rd_req(64'h4008);
        chk("cmp1 back to reset", rd_v[1], ONES);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            r  = ($urandom_range(0, 59) != 0);
            rd = ($urandom_range(0, 1) == 1);
            wr = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 19) == 0) begin
                rd = 1'b1;
                wr = 1'b1;
            end
            case ($urandom_range(0, 5))
                0:       a = {$urandom, $urandom};
                1:       a = BASE + 64'($urandom_range(0, 16'hFFFF));
                default: a = BASE + offs[$urandom_range(0, 10)];
            endcase
            d = ($urandom_range(0, 1) == 1) ? 64'($urandom_range(0, 80)) : {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       m = 8'hFF;
                1:       m = 8'h00;
                default: m = 8'($urandom_range(0, 255));
            endcase
            step(r, rd, wr, a, d, m);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
